// File: rtl/mem_wb_stage.sv
// Memory-access / write-back stage: load/store over req/gnt/rvalid, registered RF write port.
// Optional misaligned-access exceptions when MISALIGN_EXC_EN is defined.
module mem_wb_stage #(
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          ex_valid,
    output logic          ex_ready,
    input  logic [3:0]    ex_op,
    input  logic [DW-1:0] ex_addr,
    input  logic [DW-1:0] ex_sdata,
    input  logic [DW-1:0] ex_alu,
    input  logic [4:0]    ex_waddr,
    input  logic          ex_we,
    output logic          dm_req,
    output logic          dm_wr,
    output logic [DW-1:0] dm_addr,
    output logic [3:0]    dm_be,
    output logic [DW-1:0] dm_wdata,
    input  logic          dm_gnt,
    input  logic          dm_rvalid,
    input  logic [DW-1:0] dm_rdata,
    output logic          wb_we,
    output logic [4:0]    wb_waddr,
    output logic [DW-1:0] wb_wdata,
    output logic          exc_adel,
    output logic          exc_ades
);

    localparam logic [3:0] OP_LB  = 4'd1;
    localparam logic [3:0] OP_LBU = 4'd2;
    localparam logic [3:0] OP_LH  = 4'd3;
    localparam logic [3:0] OP_LHU = 4'd4;
    localparam logic [3:0] OP_LW  = 4'd5;
    localparam logic [3:0] OP_SB  = 4'd6;
    localparam logic [3:0] OP_SH  = 4'd7;
    localparam logic [3:0] OP_SW  = 4'd8;

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t        state_q, state_d;
    logic [3:0]    op_q, op_d;
    logic [DW-1:0] addr_q, addr_d;
    logic [DW-1:0] sdata_q, sdata_d;
    logic [4:0]    waddr_q, waddr_d;
    logic          we_q, we_d;
    logic          wb_we_q, wb_we_d;
    logic [4:0]    wb_waddr_q, wb_waddr_d;
    logic [DW-1:0] wb_wdata_q, wb_wdata_d;
    logic          adel_q, adel_d;
    logic          ades_q, ades_d;

    logic          ex_load, ex_store, misal;
    logic          ld_q;
    logic [7:0]    rbyte;
    logic [15:0]   rhalf;
    logic [DW-1:0] ld_data;

    assign ex_load  = (ex_op >= OP_LB) && (ex_op <= OP_LW);
    assign ex_store = (ex_op >= OP_SB) && (ex_op <= OP_SW);
    assign ld_q     = (op_q >= OP_LB) && (op_q <= OP_LW);

`ifdef MISALIGN_EXC_EN
    always_comb begin
        misal = 1'b0;
        case (ex_op)
            OP_LH, OP_LHU, OP_SH: misal = ex_addr[0];
            OP_LW, OP_SW:         misal = |ex_addr[1:0];
            default:              misal = 1'b0;
        endcase
    end
`else
    assign misal = 1'b0;
`endif

    // Little-endian lane extraction from the returned word
    assign rbyte = dm_rdata[{addr_q[1:0], 3'b000} +: 8];
    assign rhalf = dm_rdata[{addr_q[1], 4'b0000} +: 16];

    always_comb begin
        ld_data = dm_rdata;
        case (op_q)
            OP_LB:   ld_data = {{(DW-8){rbyte[7]}}, rbyte};
            OP_LBU:  ld_data = {{(DW-8){1'b0}}, rbyte};
            OP_LH:   ld_data = {{(DW-16){rhalf[15]}}, rhalf};
            OP_LHU:  ld_data = {{(DW-16){1'b0}}, rhalf};
            default: ld_data = dm_rdata;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        sdata_d    = sdata_q;
        waddr_d    = waddr_q;
        we_d       = we_q;
        wb_we_d    = 1'b0;
        wb_waddr_d = wb_waddr_q;
        wb_wdata_d = wb_wdata_q;
        adel_d     = 1'b0;
        ades_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (ex_load || ex_store) begin
                        if (misal) begin
                            adel_d = ex_load;
                            ades_d = ex_store;
                        end else begin
                            op_d    = ex_op;
                            addr_d  = ex_addr;
                            sdata_d = ex_sdata;
                            waddr_d = ex_waddr;
                            we_d    = ex_we;
                            state_d = REQ;
                        end
                    end else begin
                        wb_we_d    = ex_we && (ex_waddr != 5'd0);
                        wb_waddr_d = ex_waddr;
                        wb_wdata_d = ex_alu;
                    end
                end
            end
            REQ: begin
                if (dm_gnt) state_d = ld_q ? RESP : IDLE;
            end
            RESP: begin
                if (dm_rvalid) begin
                    wb_we_d    = we_q && (waddr_q != 5'd0);
                    wb_waddr_d = waddr_q;
                    wb_wdata_d = ld_data;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            op_q       <= 4'd0;
            addr_q     <= '0;
            sdata_q    <= '0;
            waddr_q    <= 5'd0;
            we_q       <= 1'b0;
            wb_we_q    <= 1'b0;
            wb_waddr_q <= 5'd0;
            wb_wdata_q <= '0;
            adel_q     <= 1'b0;
            ades_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            addr_q     <= addr_d;
            sdata_q    <= sdata_d;
            waddr_q    <= waddr_d;
            we_q       <= we_d;
            wb_we_q    <= wb_we_d;
            wb_waddr_q <= wb_waddr_d;
            wb_wdata_q <= wb_wdata_d;
            adel_q     <= adel_d;
            ades_q     <= ades_d;
        end
    end

    // Memory port is driven only while requesting, zero otherwise
    always_comb begin
        dm_req   = (state_q == REQ);
        dm_wr    = 1'b0;
        dm_addr  = '0;
        dm_be    = 4'b0000;
        dm_wdata = '0;
        if (dm_req) begin
            dm_wr   = !ld_q;
            dm_addr = {addr_q[DW-1:2], 2'b00};
            case (op_q)
                OP_SB: begin
                    dm_be    = 4'b0001 << addr_q[1:0];
                    dm_wdata = {(DW/8){sdata_q[7:0]}};
                end
                OP_SH: begin
                    dm_be    = addr_q[1] ? 4'b1100 : 4'b0011;
                    dm_wdata = {(DW/16){sdata_q[15:0]}};
                end
                OP_SW: begin
                    dm_be    = 4'b1111;
                    dm_wdata = sdata_q;
                end
                default: ;
            endcase
        end
    end

    assign ex_ready = (state_q == IDLE);
    assign wb_we    = wb_we_q;
    assign wb_waddr = wb_waddr_q;
    assign wb_wdata = wb_wdata_q;
    assign exc_adel = adel_q;
    assign exc_ades = ades_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage.
// Define MISALIGN_EXC_EN in both compiles to exercise the exception path.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ex_ready;
    logic [3:0]  ex_op;
    logic [31:0] ex_addr, ex_sdata, ex_alu;
    logic [4:0]  ex_waddr;
    logic        ex_we;
    logic        dm_req, dm_wr;
    logic [31:0] dm_addr, dm_wdata, dm_rdata;
    logic [3:0]  dm_be;
    logic        dm_gnt, dm_rvalid;
    logic        wb_we;
    logic [4:0]  wb_waddr;
    logic [31:0] wb_wdata;
    logic        exc_adel, exc_ades;

    int checks = 0;
    int errors = 0;

    mem_wb_stage #(.DW(32)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_op(ex_op),
        .ex_addr(ex_addr), .ex_sdata(ex_sdata), .ex_alu(ex_alu),
        .ex_waddr(ex_waddr), .ex_we(ex_we),
        .dm_req(dm_req), .dm_wr(dm_wr), .dm_addr(dm_addr),
        .dm_be(dm_be), .dm_wdata(dm_wdata),
        .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
        .exc_adel(exc_adel), .exc_ades(exc_ades)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_load(input string tag, input logic [3:0] op,
                           input logic [31:0] addr, input logic [31:0] rdata,
                           input logic [31:0] exp, input int gdly);
        ex_valid = 1'b1; ex_op = op; ex_addr = addr;
        ex_waddr = 5'd9; ex_we = 1'b1;
        tick;
        ex_valid = 1'b0;
        chk({tag, "_req"}, {31'd0, dm_req}, 32'd1);
        chk({tag, "_addr"}, dm_addr, addr & 32'hFFFF_FFFC);
        chk({tag, "_wr"}, {31'd0, dm_wr}, 32'd0);
        chk({tag, "_rdy_req"}, {31'd0, ex_ready}, 32'd0);
        for (int i = 0; i < gdly; i++) begin
            tick;
            chk({tag, "_req_hold"}, {31'd0, dm_req}, 32'd1);
        end
        // rvalid alongside the grant must be ignored
        dm_gnt = 1'b1; dm_rvalid = 1'b1; dm_rdata = ~rdata;
        tick;
        dm_gnt = 1'b0; dm_rvalid = 1'b0;
        chk({tag, "_req_off"}, {31'd0, dm_req}, 32'd0);
        chk({tag, "_rdy_resp"}, {31'd0, ex_ready}, 32'd0);
        chk({tag, "_we_early"}, {31'd0, wb_we}, 32'd0);
        dm_rvalid = 1'b1; dm_rdata = rdata;
        tick;
        dm_rvalid = 1'b0;
        chk({tag, "_we"}, {31'd0, wb_we}, 32'd1);
        chk({tag, "_waddr"}, {27'd0, wb_waddr}, 32'd9);
        chk({tag, "_data"}, wb_wdata, exp);
        chk({tag, "_rdy"}, {31'd0, ex_ready}, 32'd1);
        tick;
        chk({tag, "_we_pulse"}, {31'd0, wb_we}, 32'd0);
    endtask

    task automatic do_store(input string tag, input logic [3:0] op,
                            input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [3:0] be, input logic [31:0] wdata);
        ex_valid = 1'b1; ex_op = op; ex_addr = addr; ex_sdata = sdata;
        ex_waddr = 5'd3; ex_we = 1'b1;
        tick;
        ex_valid = 1'b0;
        chk({tag, "_req"}, {31'd0, dm_req}, 32'd1);
        chk({tag, "_wr"}, {31'd0, dm_wr}, 32'd1);
        chk({tag, "_addr"}, dm_addr, addr & 32'hFFFF_FFFC);
        chk({tag, "_be"}, {28'd0, dm_be}, {28'd0, be});
        chk({tag, "_wdata"}, dm_wdata, wdata);
        tick;
        chk({tag, "_rdy_wait"}, {31'd0, ex_ready}, 32'd0);
        chk({tag, "_be_hold"}, {28'd0, dm_be}, {28'd0, be});
        dm_gnt = 1'b1;
        tick;
        dm_gnt = 1'b0;
        chk({tag, "_rdy"}, {31'd0, ex_ready}, 32'd1);
        chk({tag, "_req_off"}, {31'd0, dm_req}, 32'd0);
        chk({tag, "_no_we"}, {31'd0, wb_we}, 32'd0);
    endtask

    initial begin
        rst = 1'b0; ex_valid = 1'b1; ex_op = 4'd0;
        ex_addr = 32'd0; ex_sdata = 32'd0; ex_alu = 32'h55;
        ex_waddr = 5'd5; ex_we = 1'b1;
        dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'd0;

        tick; tick;
        chk("rst_wb_we", {31'd0, wb_we}, 32'd0);
        chk("rst_wb_waddr", {27'd0, wb_waddr}, 32'd0);
        chk("rst_wb_wdata", wb_wdata, 32'd0);
        chk("rst_dm_req", {31'd0, dm_req}, 32'd0);
        chk("rst_dm_wr", {31'd0, dm_wr}, 32'd0);
        chk("rst_dm_addr", dm_addr, 32'd0);
        chk("rst_dm_be", {28'd0, dm_be}, 32'd0);
        chk("rst_dm_wdata", dm_wdata, 32'd0);
        chk("rst_exc", {30'd0, exc_adel, exc_ades}, 32'd0);
        rst = 1'b1; ex_valid = 1'b0;
        #1;
        chk("rst_ready", {31'd0, ex_ready}, 32'd1);

        // ALU burst r1..r4
        ex_valid = 1'b1; ex_op = 4'd0;
        for (int i = 1; i <= 4; i++) begin
            ex_waddr = 5'(i);
            ex_alu = 32'(i * 32'h11);
            tick;
            chk("alu_we", {31'd0, wb_we}, 32'd1);
            chk("alu_waddr", {27'd0, wb_waddr}, 32'(i));
            chk("alu_data", wb_wdata, 32'(i * 32'h11));
            chk("alu_ready", {31'd0, ex_ready}, 32'd1);
        end
        ex_waddr = 5'd0; ex_alu = 32'h99;
        tick;
        chk("alu_r0_no_we", {31'd0, wb_we}, 32'd0);
        ex_op = 4'd12; ex_waddr = 5'd7; ex_alu = 32'h77;
        tick;
        chk("op12_we", {31'd0, wb_we}, 32'd1);
        chk("op12_data", wb_wdata, 32'h77);
        ex_op = 4'd0; ex_we = 1'b0; ex_waddr = 5'd8;
        tick;
        chk("alu_we0", {31'd0, wb_we}, 32'd0);
        ex_valid = 1'b0; ex_we = 1'b1;
        tick;
        chk("idle_no_we", {31'd0, wb_we}, 32'd0);

        do_load("lb", 4'd1, 32'h1003, 32'h80FF_FFFF, 32'hFFFF_FF80, 2);
        do_load("lbu", 4'd2, 32'h1003, 32'h80FF_FFFF, 32'h0000_0080, 2);
        do_load("lb1", 4'd1, 32'h1001, 32'h0000_7F00, 32'h0000_007F, 0);
        do_load("lh", 4'd3, 32'h1002, 32'h8001_1234, 32'hFFFF_8001, 1);
        do_load("lhu", 4'd4, 32'h1002, 32'h8001_1234, 32'h0000_8001, 0);
        do_load("lh_lo", 4'd3, 32'h1000, 32'h8001_1234, 32'h0000_1234, 0);
        do_load("lw", 4'd5, 32'h1004, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1);

        do_store("sh", 4'd7, 32'h2002, 32'h1234_ABCD, 4'b1100, 32'hABCD_ABCD);
        do_store("sh_lo", 4'd7, 32'h2000, 32'h1234_ABCD, 4'b0011, 32'hABCD_ABCD);
        do_store("sb", 4'd6, 32'h2001, 32'h0000_005A, 4'b0010, 32'h5A5A_5A5A);
        do_store("sw", 4'd8, 32'h2004, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

        // Reset while waiting for load data abandons the access
        ex_valid = 1'b1; ex_op = 4'd5; ex_addr = 32'h1008;
        ex_waddr = 5'd10; ex_we = 1'b1;
        tick;
        ex_valid = 1'b0; dm_gnt = 1'b1;
        tick;
        dm_gnt = 1'b0;
        chk("rr_in_resp", {31'd0, ex_ready}, 32'd0);
        rst = 1'b0;
        tick;
        rst = 1'b1;
        chk("rr_ready", {31'd0, ex_ready}, 32'd1);
        dm_rvalid = 1'b1; dm_rdata = 32'h1111_2222;
        tick;
        dm_rvalid = 1'b0;
        chk("rr_no_we", {31'd0, wb_we}, 32'd0);
        chk("rr_idle", {31'd0, ex_ready}, 32'd1);
        chk("rr_wdata", wb_wdata, 32'd0);

`ifdef MISALIGN_EXC_EN
        ex_valid = 1'b1; ex_op = 4'd5; ex_addr = 32'h3001; ex_waddr = 5'd11;
        tick;
        ex_valid = 1'b0;
        chk("mis_adel", {31'd0, exc_adel}, 32'd1);
        chk("mis_ades", {31'd0, exc_ades}, 32'd0);
        chk("mis_req", {31'd0, dm_req}, 32'd0);
        chk("mis_ready", {31'd0, ex_ready}, 32'd1);
        tick;
        chk("mis_adel_pulse", {31'd0, exc_adel}, 32'd0);
        chk("mis_req2", {31'd0, dm_req}, 32'd0);
        chk("mis_no_we", {31'd0, wb_we}, 32'd0);
        ex_valid = 1'b1; ex_op = 4'd7; ex_addr = 32'h3003;
        tick;
        ex_valid = 1'b0;
        chk("mis_ades_sh", {31'd0, exc_ades}, 32'd1);
        chk("mis_req_sh", {31'd0, dm_req}, 32'd0);
`else
        do_load("lw_unal", 4'd5, 32'h3001, 32'h0BAD_F00D, 32'h0BAD_F00D, 0);
        chk("unal_exc", {30'd0, exc_adel, exc_ades}, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
